// File: rtl/shift_register.sv
// shift_register
//   Serial-in / serial-out shift register of N stages. Stage s[0] takes the
//   serial input on every rising clock edge and each stage passes its bit to
//   the next one, so a bit reaches the output after exactly N edges.
//
// Parameters
//   N   register length in bits, 1..64 (default 8)
//
// Ports
//   clk  in   single clock, rising edge
//   rst  in   asynchronous, active-high reset; clears every stage
//   si   in   serial data input
//   so   out  serial data output, taken straight from the last stage
//   q    out  N-bit parallel view of the stages, q[0] = newest bit
//             (present only when SHIFT_REGISTER_PAR_OUT_EN is defined)
//
// Build option
//   SHIFT_REGISTER_PAR_OUT_EN  define to add the parallel output port q.
//   The serial behaviour is the same in both builds.

module shift_register #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         si,
`ifdef SHIFT_REGISTER_PAR_OUT_EN
    output logic [N-1:0] q,
`endif
    output logic         so
);

    logic [N-1:0] s;

    // A single-stage register has no s[N-2:0] slice to concatenate, so it
    // gets its own branch.
    generate
        if (N == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s <= '0;
                end else begin
                    s <= si;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s <= '0;
                end else begin
                    s <= {s[N-2:0], si};
                end
            end
        end
    endgenerate

    // The output comes from a register only, so si never reaches so
    // through combinational logic.
    assign so = s[N-1];

`ifdef SHIFT_REGISTER_PAR_OUT_EN
    assign q = s;
`endif

endmodule

// File: tb/tb_shift_register.sv
module tb_shift_register;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic si8 = 1'b0;
    logic si1 = 1'b0;
    logic si5 = 1'b0;
    logic so8, so1, so5;
`ifdef SHIFT_REGISTER_PAR_OUT_EN
    logic [7:0] q8;
    logic [0:0] q1;
    logic [4:0] q5;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference history: every bit sampled since the last reset, oldest first.
    logic h8[$];
    logic h1[$];
    logic h5[$];

    always #5 clk = ~clk;

    shift_register #(.N(8)) u8 (
        .clk(clk), .rst(rst), .si(si8),
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        .q(q8),
`endif
        .so(so8)
    );

    shift_register #(.N(1)) u1 (
        .clk(clk), .rst(rst), .si(si1),
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        .q(q1),
`endif
        .so(so1)
    );

    shift_register #(.N(5)) u5 (
        .clk(clk), .rst(rst), .si(si5),
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        .q(q5),
`endif
        .so(so5)
    );

    // Bit sampled n edges ago; zero if fewer than n edges since reset.
    function automatic logic dly(input logic h[$], input int n);
        if (h.size() < n) return 1'b0;
        return h[h.size() - n];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

`ifdef SHIFT_REGISTER_PAR_OUT_EN
    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qexp8(input logic h[$]);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (h.size() > i) v[i] = h[h.size() - 1 - i];
        return v;
    endfunction
`endif

    // One clock edge: record the sampled inputs in the model, then compare
    // every output half a period later.
    task automatic tick();
        @(posedge clk);
        h8.push_back(si8);
        h1.push_back(si1);
        h5.push_back(si5);
        if (h8.size() > 70) void'(h8.pop_front());
        if (h1.size() > 70) void'(h1.pop_front());
        if (h5.size() > 70) void'(h5.pop_front());
        @(negedge clk);
        chk("so8_model", so8, dly(h8, 8));
        chk("so1_model", so1, dly(h1, 1));
        chk("so5_model", so5, dly(h5, 5));
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        chk8("q8_model", q8, qexp8(h8));
`endif
    endtask

    // Reset pulse placed between edges; outputs must clear before any edge.
    task automatic pulse_rst(input string tag);
        #1 rst = 1'b1;
        #1;
        chk({tag, "_so8"}, so8, 1'b0);
        chk({tag, "_so1"}, so1, 1'b0);
        chk({tag, "_so5"}, so5, 1'b0);
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        chk8({tag, "_q8"}, q8, 8'h00);
`endif
        h8.delete();
        h1.delete();
        h5.delete();
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic       exp8;

        // Reset while the clock has not yet produced a rising edge.
        pulse_rst("rst_idle");

        // Fill with ones, a single zero sampled at edge 12.
        for (int k = 1; k <= 30; k++) begin
            si8 = (k == 12) ? 1'b0 : 1'b1;
            si1 = ~si1;
            si5 = 1'($urandom);
            tick();
            exp8 = (k < 8 || k == 19) ? 1'b0 : 1'b1;
            chk("fill_zero_so8", so8, exp8);
`ifdef SHIFT_REGISTER_PAR_OUT_EN
            if (k == 8) chk8("fill_q8", q8, 8'hFF);
`endif
        end

        // Load a known pattern, first bit ends up in the last stage.
        pat = 8'b10110010;
        for (int i = 7; i >= 0; i--) begin
            si8 = pat[i];
            si1 = ~si1;
            si5 = 1'($urandom);
            tick();
        end
        chk("pat_so8", so8, pat[7]);
`ifdef SHIFT_REGISTER_PAR_OUT_EN
        chk8("pat_q8", q8, pat);
`endif

        // Reset in the middle of operation, then shifting restarts from zero.
        pulse_rst("rst_mid");
        for (int k = 1; k <= 12; k++) begin
            si8 = 1'b1;
            si1 = ~si1;
            si5 = 1'($urandom);
            tick();
            chk("restart_so8", so8, (k >= 8) ? 1'b1 : 1'b0);
        end

        // Long random run on all instances.
        for (int k = 0; k < 1000; k++) begin
            si8 = 1'($urandom);
            si1 = 1'($urandom);
            si5 = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register.md
SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter N, default 8, SHALL set the register length in bits; legal range 1..64.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port si, input, 1 bit, SHALL be the serial data input, sampled on each rising clk edge.
REQ-005 Port so, output, 1 bit, SHALL be the serial data output, driven directly from the last stage with no combinational path from si.
REQ-006 Port q, output, N bits, SHALL exist only when SHIFT_REGISTER_PAR_OUT_EN is defined (see REQ-016).

Function
REQ-007 The block SHALL hold an N-bit internal state s[N-1:0], with s[0] as the first stage and s[N-1] as the last stage.
REQ-008 On every rising clk edge with rst low, the block SHALL update s to {s[N-2:0], si}; for N=1, s[0] SHALL take si.
REQ-009 so SHALL equal s[N-1] at all times.
REQ-010 Latency: a value presented on si before rising edge k SHALL appear on so immediately after rising edge k+N-1, i.e. after exactly N sampling edges, and SHALL hold for one clock period.
REQ-011 The shift SHALL occur on every edge (no enable, no hold state); each bit SHALL be delayed by N edges exactly, without loss or duplication.
REQ-012 X or Z on si SHALL propagate through the stages unchanged, with no masking; X or Z SHALL NOT be converted into a known value.

Reset
REQ-013 While rst is high, s SHALL be all zeros and so SHALL be 0, independent of clk; q, when present, SHALL also be 0.
REQ-014 Reset asserted mid-shift SHALL clear all stages immediately, without waiting for a clock edge, and SHALL discard in-flight data.
REQ-015 On deassertion of rst, the first rising edge with rst low SHALL load si into s[0]; after that edge, so SHALL remain 0 for N-1 further edges and then follow REQ-010.

Configuration
REQ-016 Macro SHIFT_REGISTER_PAR_OUT_EN defined: the block SHALL provide port q[N-1:0] = s, with q[0] holding the newest bit.
REQ-017 Macro SHIFT_REGISTER_PAR_OUT_EN undefined: port q SHALL be absent, and the serial behaviour SHALL be identical to the defined case.

Verification
REQ-018 Reset: set rst=1 with clk idle -> so=0 immediately (and q=8'h00); release rst -> so stays 0 until data arrives.
REQ-019 Fill: N=8, si=1 on every edge starting at edge 1 -> so=0 through edge 7; so=1 after edge 8 and stays 1 (q=8'hFF after edge 8).
REQ-020 Single zero: N=8, stream 1s with a single 0 sampled at edge 12 -> so=0 for exactly one period after edge 19, and 1 before and after it.
REQ-021 Mid-operation reset: N=8, load pattern 10110010 over edges 1-8, then pulse rst between edges -> so and q read 0 at once; subsequent shifting restarts from all zeros.
REQ-022 N=1: toggle si on each edge -> so equals the si sampled at the previous edge (one-edge latency).
REQ-023 Random: 1000 random si bits with N=5 -> so matches si delayed by 5 edges, checked at every cycle.
